// File: rtl/otter_pkg.sv
// ============================================================================
// Module  : otter_pkg
// Purpose : Opcode encodings shared by the OTTER decoder and sequencing FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP_RG3 = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [2:0] F3_MRET = 3'b000;

    // CSRRW / CSRRS / CSRRC: the register forms that write both rd and a CSR.
    function automatic logic is_csr_access(input logic [2:0] func3);
        return (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b011);
    endfunction

endpackage

`default_nettype wire

// File: rtl/otter_cu_fsm.sv
// ============================================================================
// Module  : otter_cu_fsm
// Purpose : Multicycle OTTER sequencer: fetch/exec/writeback/interrupt timing
//           plus a retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             intr,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    output logic             pcWrite,
    output logic             regWrite,
    output logic             memWE2,
    output logic             memRDEN1,
    output logic             memRDEN2,
    output logic             rst_out,
    output logic             csr_we,
    output logic             int_taken,
    output logic             mret_exec,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t  state;
    state_t  next_state;
    logic    retire;
    opcode_t op;

    assign op = opcode_t'(opcode);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_INIT;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instret <= instret + CNT_ONE;
            end
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        memWE2     = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        rst_out    = 1'b0;
        csr_we     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;

        case (state)
            ST_INIT: begin
                rst_out    = 1'b1;
                next_state = ST_FETCH;
            end

            ST_FETCH: begin
                memRDEN1   = 1'b1;
                next_state = ST_EXEC;
            end

            ST_EXEC: begin
                if (op == LOAD) begin
                    // Data arrives one cycle later; the load retires out of WB.
                    memRDEN2   = 1'b1;
                    next_state = ST_WB;
                end else begin
                    pcWrite    = 1'b1;
                    retire     = 1'b1;
                    next_state = intr ? ST_INTR : ST_FETCH;
                    case (op)
                        STORE: memWE2 = 1'b1;
                        LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: regWrite = 1'b1;
                        SYSTEM: begin
                            if (func3 == F3_MRET) begin
                                mret_exec = 1'b1;
                            end else if (is_csr_access(func3)) begin
                                regWrite = 1'b1;
                                csr_we   = 1'b1;
                            end
                        end
                        default: ;  // BRANCH and unknown opcodes only advance the PC
                    endcase
                end
            end

            ST_WB: begin
                regWrite   = 1'b1;
                pcWrite    = 1'b1;
                retire     = 1'b1;
                next_state = intr ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                int_taken  = 1'b1;
                pcWrite    = 1'b1;
                next_state = ST_FETCH;
            end

            default: next_state = ST_INIT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
// ============================================================================
// Module  : tb_otter_cu_fsm
// Purpose : Self-checking bench for otter_cu_fsm (32-bit and 4-bit counters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_otter_cu_fsm;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        intr = 1'b0;
    logic [6:0]  opcode = 7'b0010011;
    logic [2:0]  func3 = 3'b000;

    logic        pc_w, rg_w, we2, rd1, rd2, rso, csr, itk, mret;
    logic [31:0] instret;
    logic        pc_w4, rg_w4, we24, rd14, rd24, rso4, csr4, itk4, mret4;
    logic [3:0]  instret4;

    int n_checks = 0;
    int n_errors = 0;
    longint unsigned model_cnt = 0;

    // Output vector bit positions.
    localparam logic [8:0] O_PC   = 9'h100;
    localparam logic [8:0] O_RW   = 9'h080;
    localparam logic [8:0] O_WE2  = 9'h040;
    localparam logic [8:0] O_RD1  = 9'h020;
    localparam logic [8:0] O_RD2  = 9'h010;
    localparam logic [8:0] O_RST  = 9'h008;
    localparam logic [8:0] O_CSR  = 9'h004;
    localparam logic [8:0] O_INT  = 9'h002;
    localparam logic [8:0] O_MRET = 9'h001;
    localparam logic [8:0] O_WB   = O_PC | O_RW;
    localparam logic [8:0] O_INTR = O_PC | O_INT;

    always #5 CLK = ~CLK;

    otter_cu_fsm #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .intr(intr), .opcode(opcode), .func3(func3),
        .pcWrite(pc_w), .regWrite(rg_w), .memWE2(we2), .memRDEN1(rd1),
        .memRDEN2(rd2), .rst_out(rso), .csr_we(csr), .int_taken(itk),
        .mret_exec(mret), .instret(instret)
    );

    otter_cu_fsm #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .intr(intr), .opcode(opcode), .func3(func3),
        .pcWrite(pc_w4), .regWrite(rg_w4), .memWE2(we24), .memRDEN1(rd14),
        .memRDEN2(rd24), .rst_out(rso4), .csr_we(csr4), .int_taken(itk4),
        .mret_exec(mret4), .instret(instret4)
    );

    wire [8:0] outs  = {pc_w, rg_w, we2, rd1, rd2, rso, csr, itk, mret};
    wire [8:0] outs4 = {pc_w4, rg_w4, we24, rd14, rd24, rso4, csr4, itk4, mret4};

    // Reference decode of the EXEC cycle written straight from the opcode rules.
    function automatic logic [8:0] exec_ref(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return O_RD2;
            7'b0100011: return O_PC | O_WE2;
            7'b1100011: return O_PC;
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0010011, 7'b0110011: return O_PC | O_RW;
            7'b1110011: begin
                if (f3 == 3'd0) return O_PC | O_MRET;
                if (f3 >= 3'd1 && f3 <= 3'd3) return O_PC | O_RW | O_CSR;
                return O_PC;
            end
            default: return O_PC;
        endcase
    endfunction

    task automatic check_now(input logic [8:0] exp, input string tag);
        n_checks++;
        if (outs !== exp || outs4 !== exp) begin
            n_errors++;
            $display("FAIL %s: outs=%b outs4=%b expected=%b", tag, outs, outs4, exp);
        end
        n_checks++;
        if (instret !== model_cnt[31:0] || instret4 !== model_cnt[3:0]) begin
            n_errors++;
            $display("FAIL %s_instret: instret=%0d instret4=%0d expected=%0d/%0d",
                     tag, instret, instret4, model_cnt[31:0], model_cnt[3:0]);
        end
    endtask

    // Inputs are set by the caller just after a rising edge; sample at the falling edge.
    task automatic check_cycle(input logic [8:0] exp, input string tag);
        @(negedge CLK);
        check_now(exp, tag);
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        model_cnt = 0;
        #1;
        check_now(O_RST, "reset_async");
        repeat (3) check_cycle(O_RST, "reset_hold");
        RST = 1'b0;
        check_cycle(O_RST, "reset_release");
    endtask

    // One instruction at transaction level: fetch, exec, optional WB, optional trap entry.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic [8:0] exp_exec,
                            input logic i_f, input logic i_e,
                            input logic i_w, input logic i_t);
        logic take;
        opcode = op;
        func3  = f3;
        intr   = i_f;
        check_cycle(O_RD1, "fetch");
        intr = i_e;
        check_cycle(exp_exec, "exec");
        if (op == 7'b0000011) begin
            intr = i_w;
            check_cycle(O_WB, "wb");
            take = i_w;
        end else begin
            take = i_e;
        end
        model_cnt++;
        if (take) begin
            intr = i_t;
            check_cycle(O_INTR, "intr");
        end
        intr = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       irq;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [6:0] ops[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation timed out, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{7'b0010011, 3'b000, 1'b0, O_PC | O_RW};
        vecs[1]  = '{7'b0000011, 3'b010, 1'b0, O_RD2};
        vecs[2]  = '{7'b0100011, 3'b010, 1'b1, O_PC | O_WE2};
        vecs[3]  = '{7'b1100011, 3'b001, 1'b0, O_PC};
        vecs[4]  = '{7'b0110111, 3'b000, 1'b0, O_PC | O_RW};
        vecs[5]  = '{7'b1101111, 3'b000, 1'b1, O_PC | O_RW};
        vecs[6]  = '{7'b1110011, 3'b001, 1'b0, O_PC | O_RW | O_CSR};
        vecs[7]  = '{7'b1110011, 3'b000, 1'b0, O_PC | O_MRET};
        vecs[8]  = '{7'b1110011, 3'b100, 1'b0, O_PC};
        vecs[9]  = '{7'b1110011, 3'b011, 1'b1, O_PC | O_RW | O_CSR};
        vecs[10] = '{7'b0000000, 3'b000, 1'b0, O_PC};
        vecs[11] = '{7'b0000011, 3'b000, 1'b1, O_RD2};

        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                7'b0000011, 7'b1110011};

        #2;
        apply_reset();

        // Table-driven decode; the irq flag is held for the whole instruction.
        for (int i = 0; i < 12; i++) begin
            do_instr(vecs[i].op, vecs[i].f3, vecs[i].exp,
                     vecs[i].irq, vecs[i].irq, vecs[i].irq, vecs[i].irq);
        end

        // Pulses outside the retire edge must be ignored.
        do_instr(7'b0010011, 3'b000, O_PC | O_RW, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr(7'b0000011, 3'b000, O_RD2, 1'b0, 1'b0, 1'b0, 1'b0);
        opcode = 7'b0000011;
        intr   = 1'b1;
        check_cycle(O_RD1, "ld_fetch_pulse");
        check_cycle(O_RD2, "ld_exec_pulse");
        intr = 1'b0;
        check_cycle(O_WB, "ld_wb_nopulse");
        model_cnt++;
        check_cycle(O_RD1, "ld_back_to_fetch");
        check_cycle(O_RD2, "ld_exec2");

        // Reset asserted mid-WB takes effect without a clock edge.
        @(negedge CLK);
        check_now(O_WB, "pre_reset_wb");
        #1;
        RST = 1'b1;
        model_cnt = 0;
        #1;
        check_now(O_RST, "reset_mid_wb");
        @(posedge CLK);
        #1;
        check_now(O_RST, "reset_mid_wb_edge");
        RST = 1'b0;
        check_cycle(O_RST, "reset_mid_wb_release");

        // Randomized instructions against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            f3 = 3'($urandom);
            do_instr(op, f3, exec_ref(op, f3),
                     1'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Counter wrap: 17 retirements on a 4-bit counter leave 1.
        apply_reset();
        for (int n = 0; n < 17; n++) begin
            do_instr(7'b0110011, 3'b000, O_PC | O_RW, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (instret4 !== 4'd1 || instret !== 32'd17) begin
            n_errors++;
            $display("FAIL wrap: instret4=%0d instret=%0d expected=1/17", instret4, instret);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
